// File: rtl/glm_pkg.sv
// Shared constants and ANF helpers for the two-stage domain-select S/T pipeline.
package glm_pkg;

   localparam int NIB_W   = 4;
   localparam int PROD_W  = 6;
   localparam int IDX_AB  = 0;
   localparam int IDX_AC  = 1;
   localparam int IDX_AD  = 2;
   localparam int IDX_BC  = 3;
   localparam int IDX_BD  = 4;
   localparam int IDX_CD  = 5;

   // Degree-2 products of a=n[0], b=n[1], c=n[2], d=n[3].
   function automatic logic [PROD_W-1:0] prod2(input logic [NIB_W-1:0] n);
      logic [PROD_W-1:0] p;
      p         = 6'b000000;
      p[IDX_AB] = n[0] & n[1];
      p[IDX_AC] = n[0] & n[2];
      p[IDX_AD] = n[0] & n[3];
      p[IDX_BC] = n[1] & n[2];
      p[IDX_BD] = n[1] & n[3];
      p[IDX_CD] = n[2] & n[3];
      return p;
   endfunction

   function automatic logic [NIB_W-1:0] s_anf(input logic [NIB_W-1:0] n,
                                              input logic [PROD_W-1:0] p);
      logic abc, abd, acd, bcd;
      logic [NIB_W-1:0] s;
      abc  = p[IDX_AB] & n[2];
      abd  = p[IDX_AB] & n[3];
      acd  = p[IDX_AC] & n[3];
      bcd  = p[IDX_BC] & n[3];
      s[0] = abc ^ p[IDX_CD] ^ p[IDX_AB];
      s[1] = abc ^ bcd ^ p[IDX_AC];
      s[2] = abd ^ bcd ^ p[IDX_AD] ^ n[0];
      s[3] = p[IDX_BC] ^ p[IDX_BD] ^ p[IDX_CD] ^ abc ^ abd ^ acd;
      return s;
   endfunction

   function automatic logic [NIB_W-1:0] t_anf(input logic [NIB_W-1:0] n,
                                              input logic [PROD_W-1:0] p);
      logic abc, abd, acd, bcd;
      logic [NIB_W-1:0] t;
      abc  = p[IDX_AB] & n[2];
      abd  = p[IDX_AB] & n[3];
      acd  = p[IDX_AC] & n[3];
      bcd  = p[IDX_BC] & n[3];
      t[0] = abd ^ acd ^ p[IDX_CD] ^ p[IDX_AB];
      t[1] = abc ^ p[IDX_AC] ^ p[IDX_CD];
      t[2] = abc ^ abd ^ p[IDX_AB] ^ p[IDX_BD] ^ n[0];
      t[3] = p[IDX_AC] ^ abc ^ acd ^ bcd;
      return t;
   endfunction

endpackage

// File: rtl/glm_domain_lane.sv
// One lane: domain select, stage-1 degree-2 products, stage-2 S/T nibbles.
// GLM_REFRESH_EN adds an 8-bit rnd mask applied on the stage-1-to-2 transfer.
module glm_domain_lane
   import glm_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ld1,
   input  logic        ld2,
   input  logic [3:0]  dom_sel,
   input  logic [3:0]  share_a,
   input  logic [3:0]  share_b,
`ifdef GLM_REFRESH_EN
   input  logic [7:0]  rnd,
`endif
   output logic [3:0]  s_out,
   output logic [3:0]  t_out
);

   logic [NIB_W-1:0]  n_s;
   logic [NIB_W-1:0]  n_r;
   logic [PROD_W-1:0] prod_s;
   logic [PROD_W-1:0] prod_r;
   logic [NIB_W-1:0]  s_s;
   logic [NIB_W-1:0]  t_s;

   // Share recombination and next-stage S/T from the registered products.
   always_comb begin
      n_s    = (share_b & dom_sel) | (share_a & ~dom_sel);
      prod_s = prod2(n_s);
`ifdef GLM_REFRESH_EN
      s_s    = s_anf(n_r, prod_r) ^ rnd[3:0];
      t_s    = t_anf(n_r, prod_r) ^ rnd[7:4];
`else
      s_s    = s_anf(n_r, prod_r);
      t_s    = t_anf(n_r, prod_r);
`endif
   end

   // Stage 1: nibble and products, held while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_r    <= 4'h0;
         prod_r <= 6'h00;
      end else if (ld1) begin
         n_r    <= n_s;
         prod_r <= prod_s;
      end else begin
         n_r    <= n_r;
         prod_r <= prod_r;
      end
   end

   // Stage 2: S/T output registers, held while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_out <= 4'h0;
         t_out <= 4'h0;
      end else if (ld2) begin
         s_out <= s_s;
         t_out <= t_s;
      end else begin
         s_out <= s_out;
         t_out <= t_out;
      end
   end

endmodule

// File: rtl/glm_domain_pipe.sv
// LANES-wide two-stage S/T pipeline with valid/ready flow control.
// Optional macro GLM_REFRESH_EN adds the rnd masking input.
module glm_domain_pipe
   import glm_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [4*LANES-1:0] dom_sel,
   input  logic [4*LANES-1:0] share_a,
   input  logic [4*LANES-1:0] share_b,
`ifdef GLM_REFRESH_EN
   input  logic [8*LANES-1:0] rnd,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [4*LANES-1:0] s_out,
   output logic [4*LANES-1:0] t_out
);

   logic v1_r;
   logic v2_r;
   logic en1_s;
   logic en2_s;
   logic ld1_s;
   logic ld2_s;

   // A stage may take new data when it is empty or its content moves on.
   always_comb begin
      en2_s = !v2_r || out_ready;
      en1_s = !v1_r || en2_s;
      ld1_s = en1_s && in_valid;
      ld2_s = en2_s && v1_r;
   end

   assign in_ready  = en1_s;
   assign out_valid = v2_r;

   // Stage valid flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_r <= 1'b0;
         v2_r <= 1'b0;
      end else begin
         v1_r <= en1_s ? in_valid : v1_r;
         v2_r <= en2_s ? v1_r : v2_r;
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      glm_domain_lane u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .ld1     (ld1_s),
         .ld2     (ld2_s),
         .dom_sel (dom_sel[4*k +: 4]),
         .share_a (share_a[4*k +: 4]),
         .share_b (share_b[4*k +: 4]),
`ifdef GLM_REFRESH_EN
         .rnd     (rnd[8*k +: 8]),
`endif
         .s_out   (s_out[4*k +: 4]),
         .t_out   (t_out[4*k +: 4])
      );
   end

endmodule

// File: tb/tb_glm_domain_pipe.sv
// Scoreboard bench for glm_domain_pipe; define GLM_REFRESH_EN to cover masking.
module tb_glm_domain_pipe;

   localparam int LANES = 4;
   localparam int W     = 4 * LANES;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [W-1:0]   dom_sel = '0;
   logic [W-1:0]   share_a = '0;
   logic [W-1:0]   share_b = '0;
   logic [2*W-1:0] rnd = '0;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [W-1:0]   s_out;
   logic [W-1:0]   t_out;

   int tests_run = 0;
   int tests_failed = 0;
   int acc_cnt = 0;
   int rel_cnt = 0;
   logic [2*W-1:0] exp_q[$];

   glm_domain_pipe #(.LANES(LANES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dom_sel   (dom_sel),
      .share_a   (share_a),
      .share_b   (share_b),
`ifdef GLM_REFRESH_EN
      .rnd       (rnd),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s_out     (s_out),
      .t_out     (t_out)
   );

   always #5 clk = ~clk;

   // Golden S/T per nibble, written straight from the ANF equations.
   function automatic logic [7:0] golden(input logic [3:0] n, input logic [7:0] r);
      logic a, b, c, d;
      logic [3:0] s, t;
      a = n[0]; b = n[1]; c = n[2]; d = n[3];
      s[0] = (a&b&c) ^ (c&d) ^ (a&b);
      s[1] = (a&b&c) ^ (b&c&d) ^ (a&c);
      s[2] = (a&b&d) ^ (b&c&d) ^ (a&d) ^ a;
      s[3] = (b&c) ^ (b&d) ^ (c&d) ^ (a&b&c) ^ (a&b&d) ^ (a&c&d);
      t[0] = (a&b&d) ^ (a&c&d) ^ (c&d) ^ (a&b);
      t[1] = (a&b&c) ^ (a&c) ^ (c&d);
      t[2] = (a&b&c) ^ (a&b&d) ^ (a&b) ^ (b&d) ^ a;
      t[3] = (a&c) ^ (a&b&c) ^ (a&c&d) ^ (b&c&d);
`ifdef GLM_REFRESH_EN
      s = s ^ r[3:0];
      t = t ^ r[7:4];
`endif
      return {t, s};
   endfunction

   // Expected {t_out, s_out} for the inputs currently driven.
   function automatic logic [2*W-1:0] model();
      logic [W-1:0] s, t;
      logic [3:0] n;
      logic [7:0] g;
      for (int k = 0; k < LANES; k++) begin
         n = (share_b[4*k +: 4] & dom_sel[4*k +: 4]) | (share_a[4*k +: 4] & ~dom_sel[4*k +: 4]);
         g = golden(n, rnd[8*k +: 8]);
         s[4*k +: 4] = g[3:0];
         t[4*k +: 4] = g[7:4];
      end
      return {t, s};
   endfunction

   // Scoreboard: push on accept, pop and compare on release, sampled mid-cycle.
   always @(negedge clk) begin
      #2;
      if (rst_n) begin
         if (in_valid && in_ready) begin
            exp_q.push_back(model());
            acc_cnt++;
         end
         if (out_valid && out_ready) begin
            logic [2*W-1:0] e;
            rel_cnt++;
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("FAIL sb_extra: got s=%h t=%h, required no output", s_out, t_out);
            end else begin
               e = exp_q.pop_front();
               if ({t_out, s_out} !== e) begin
                  tests_failed++;
                  $display("FAIL sb_data: got s=%h t=%h, required s=%h t=%h",
                           s_out, t_out, e[W-1:0], e[2*W-1:W]);
               end
            end
         end
      end
   end

   task automatic set_all(input logic [3:0] sel, input logic [3:0] a, input logic [3:0] b);
      dom_sel = {LANES{sel}};
      share_a = {LANES{a}};
      share_b = {LANES{b}};
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || s_out !== '0 || t_out !== '0) begin
         tests_failed++;
         $display("FAIL reset_state: got ov=%b ir=%b s=%h t=%h, required 0 1 0 0",
                  out_valid, in_ready, s_out, t_out);
      end
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One beat, then check the output two cycles later against a constant.
   task automatic test_single(input string name, input logic [3:0] sel, input logic [3:0] a,
                              input logic [3:0] b, input logic [3:0] es, input logic [3:0] et);
      @(negedge clk);
      set_all(sel, a, b);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      tests_run++;
      if (out_valid !== 1'b1 || s_out !== {LANES{es}} || t_out !== {LANES{et}}) begin
         tests_failed++;
         $display("FAIL %s: got ov=%b s=%h t=%h, required ov=1 s=%h t=%h",
                  name, out_valid, s_out, t_out, {LANES{es}}, {LANES{et}});
      end
      @(negedge clk);
   endtask

   task automatic test_vectors();
      rnd = '0;
      test_single("vec_f", 4'h0, 4'hF, 4'h0, 4'h3, 4'h6);
      test_single("vec_b1", 4'h1, 4'h0, 4'h1, 4'h4, 4'h4);
      test_single("vec_a3", 4'h0, 4'h3, 4'h0, 4'h5, 4'h1);
   endtask

   task automatic test_backpressure();
      logic [W-1:0] hold_s, hold_t;
      int base;
      base = rel_cnt;
      hold_s = '0;
      hold_t = '0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         out_ready = 1'b0;
         in_valid  = 1'b1;
         set_all(4'h0, 4'(k + 5), 4'h0);
         #1;
         tests_run++;
         if (in_ready !== (k < 2)) begin
            tests_failed++;
            $display("FAIL bp_in_ready%0d: got %b, required %b", k, in_ready, (k < 2));
         end
         if (k == 2) begin
            hold_s = s_out;
            hold_t = t_out;
         end else if (k > 2) begin
            tests_run++;
            if (s_out !== hold_s || t_out !== hold_t || out_valid !== 1'b1) begin
               tests_failed++;
               $display("FAIL bp_hold%0d: got ov=%b s=%h t=%h, required ov=1 s=%h t=%h",
                        k, out_valid, s_out, t_out, hold_s, hold_t);
            end
         end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      #3;
      tests_run++;
      if (rel_cnt - base !== 2 || exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL bp_drain: got %0d released q=%0d, required 2 released q=0",
                  rel_cnt - base, exp_q.size());
      end
   endtask

   task automatic test_random();
      int a0, r0, sent, cyc;
      a0 = acc_cnt;
      r0 = rel_cnt;
      cyc = 0;
      sent = 0;
      while (sent < 1000 && cyc < 20000) begin
         @(negedge clk);
         sent = acc_cnt - a0;
         in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         dom_sel = W'($urandom);
         share_a = W'($urandom);
         share_b = W'($urandom);
         cyc++;
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      #3;
      tests_run++;
      if (acc_cnt - a0 != 1000 || rel_cnt - r0 != 1000 || exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL rand_count: got in=%0d out=%0d q=%0d, required 1000 1000 0",
                  acc_cnt - a0, rel_cnt - r0, exp_q.size());
      end
   endtask

   task automatic test_reset_midflight();
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      set_all(4'h0, 4'hA, 4'h0);
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL midrst: got ov=%b ir=%b, required 0 1", out_valid, in_ready);
      end
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #1;
         tests_run++;
         if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_stale: got ov=%b s=%h, required ov=0", out_valid, s_out);
         end
      end
      test_single("post_rst", 4'h0, 4'hF, 4'h0, 4'h3, 4'h6);
   endtask

`ifdef GLM_REFRESH_EN
   task automatic test_refresh();
      rnd = {LANES{8'hFF}};
      test_single("refresh", 4'h0, 4'hF, 4'h0, 4'hC, 4'h9);
      rnd = '0;
   endtask
`endif

   initial begin
      test_reset();
      test_vectors();
      test_backpressure();
      test_random();
      test_reset_midflight();
`ifdef GLM_REFRESH_EN
      test_refresh();
`endif
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
